kpg_prefix_adder_pl: RTL
========================

// Module: kpg_prefix_adder_pl
// PURPOSE
//  Parametrised, pipelined Kogge-Stone adder/subtractor built on KPG (kill/propagate/generate) prefix cells.
//  Registers each prefix level; valid/ready stream handshake with full-pipeline stall; signed/unsigned flags.
//  Sits in the Wallace multiplier datapath as the final carry-propagate adder.
//  Also serves as a standalone ALU adder for any width.
// PARAMETERS
//  WIDTH  16  operand width in bits, >= 2; need not be a power of two
//  LOG2W  $clog2(WIDTH)  number of prefix levels (derived, do not override)
//  LAT    LOG2W+2  latency in accepted cycles: input reg + LOG2W level regs + output reg
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept a beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (ignored when sub=1)
//  sub        in   1      1: A-B computed as A+~B+1
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result bits [WIDTH-1:0]
//  cout       out  1      carry out (sub: 1 = no borrow)
//  ovf        out  1      signed two's-complement overflow
//  zero       out  1      sum == 0
// BEHAVIOUR
//  - KPG encoding: K=2'b00, P=2'b01, G=2'b11. Per-bit: a&b->G, a^b->P, else K; bit-(-1) slot = cin ? G : K.
//  - Combine cell: hi=K->K, hi=G->G, hi=P->lo. Level l (0..LOG2W-1) combines slot i with i-2^l for i>=2^l.
//    Slots below 2^l pass through unchanged.
//  - carry into bit i = final KPG slot (i-1) bit0; sum[i]=a[i]^b'[i]^carry; cout = final slot WIDTH-1 bit0.
//    b' = sub ? ~b : b; effective cin = sub | cin.
//  - ovf = (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]). zero = ~|sum.
//  - Pipeline: a, b', per-bit P bits and the valid bit travel alongside each level register.
//    Sum is formed from the level-LOG2W register into the output register.
//  - Stall: adv = ~out_valid | out_ready. in_ready = adv. When adv=0 every stage, including valid bits, holds.
//  - Beat accepted iff in_valid & in_ready. Result appears with out_valid=1 exactly LAT advancing cycles later.
//    With no stall, LAT clock cycles later.
//  - Bubbles (in_valid=0 while adv) propagate as valid=0; order is strictly preserved.
//    Throughput is 1 beat/cycle when out_ready=1.
//  - out_valid, sum, cout, ovf, zero hold stable while out_valid & ~out_ready.
//  - Reset: all stage valid bits <= 0. out_valid=0, sum=0, cout=0, ovf=0, zero=0 in the cycle after rst is sampled.
//    in_ready=1 during and after reset (out_valid=0).
//  - Reset mid-operation: all in-flight beats are discarded, none emerge later. rst has priority over in_valid.
//  - Data registers of invalid stages may hold stale values; only valid-qualified outputs are defined.
//  - Non-power-of-two WIDTH: the top level still spans 2^(LOG2W-1); slots beyond WIDTH-1 do not exist.
// TESTING (WIDTH=16, LAT=6 unless noted)
//  1. 0xFFFF+0x0001, cin=0, sub=0, out_ready=1 -> 6 cycles later sum=0x0000, cout=1, zero=1, ovf=0.
//  2. sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0. a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1, cout=1.
//  3. 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0; 0x1234+0x4321, cin=1 -> 0x5556.
//  4. Stream 20 random beats. Hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the hold.
//     No beat is lost or duplicated; order matches a reference model.
//  5. Assert rst for 1 cycle with 4 beats in flight -> out_valid=0 next cycle.
//     No stale beat appears within the next 8 cycles; a new beat returns after 6 cycles.
//  6. WIDTH=12 (LOG2W=4, LAT=6) and WIDTH=8 (LAT=5): exhaustive random vs a+b+cin model,
//     including 0xFFF+0x001 -> sum=0, cout=1.

Source files
------------

// File: rtl/kpg_prefix_adder_pl_if.sv
// Stream bus for the pipelined KPG prefix adder: operand beat in, result beat out.
interface kpg_prefix_adder_pl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    // Producer/consumer side (drives operands, accepts results)
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    // Adder side
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/kpg_prefix_adder_pl.sv
// Pipelined Kogge-Stone adder/subtractor on KPG prefix cells.
// Stages: input reg -> LOG2W prefix level regs -> output reg, with a
// whole-pipeline stall whenever a valid result is not taken downstream.

// KPG combine cell: a killing or generating upper span decides the result,
// a propagating upper span forwards whatever the lower span produces.
module kpg_cell (
    input  logic [1:0] hi,
    input  logic [1:0] lo,
    output logic [1:0] o
);
    assign o = (hi == 2'b01) ? lo : hi;
endmodule

module kpg_prefix_adder_pl #(
    parameter int WIDTH = 16,
    localparam int LOG2W = $clog2(WIDTH),
    localparam int LAT   = LOG2W + 2
) (
    input logic                 clk,
    input logic                 rst,
    kpg_prefix_adder_pl_if.slave bus
);
    localparam int STAGES = LAT - 1;
    localparam logic [1:0] KPG_K = 2'b00;
    localparam logic [1:0] KPG_P = 2'b01;
    localparam logic [1:0] KPG_G = 2'b11;

    // vld_pipe[0] = input reg, [1..LOG2W] = level regs, [STAGES] = output reg
    logic [STAGES:0] vld_pipe;
    logic            adv;

    // Input stage
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_bp;
    logic             in_cin;

    // Prefix network
    logic [WIDTH-1:0][1:0]             kpg0;
    logic [LOG2W-1:0][WIDTH-1:0][1:0]  lvl_nxt;
    logic [LOG2W-1:0][WIDTH-1:0][1:0]  lvl_q;

    // Side-band travelling with each level register
    logic [LOG2W-1:0][WIDTH-1:0] p_q;
    logic [LOG2W-1:0]            am_q;
    logic [LOG2W-1:0]            bm_q;
    logic [LOG2W-1:0]            c_q;

    // Result formation
    logic [WIDTH-1:0][1:0] fin;
    logic [WIDTH-1:0]      carry;
    logic [WIDTH-1:0]      sum_d;
    logic                  cout_d;
    logic                  ovf_d;
    logic                  zero_d;
    logic [WIDTH-1:0]      unused_fin_hi;

    assign adv           = ~vld_pipe[STAGES] | bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_pipe[STAGES];

    // Per-bit KPG from the registered operands; carry-in is folded into bit 0
    // so the LOG2W levels only ever have to span WIDTH slots.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            if (in_a[i] & in_bp[i])
                kpg0[i] = KPG_G;
            else if (in_a[i] ^ in_bp[i])
                kpg0[i] = KPG_P;
            else
                kpg0[i] = KPG_K;
        end
        if (kpg0[0] == KPG_P)
            kpg0[0] = in_cin ? KPG_G : KPG_K;
    end

    // Kogge-Stone levels: slot i merges with slot i-2^l, lower slots pass through
    for (genvar l = 0; l < LOG2W; l++) begin : g_lvl
        localparam int D = 1 << l;
        logic [WIDTH-1:0][1:0] src;

        if (l == 0) begin : g_first
            assign src = kpg0;
        end else begin : g_next
            assign src = lvl_q[l-1];
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_slot
            if (i >= D) begin : g_cell
                kpg_cell u_cell (
                    .hi (src[i]),
                    .lo (src[i-D]),
                    .o  (lvl_nxt[l][i])
                );
            end else begin : g_pass
                assign lvl_nxt[l][i] = src[i];
            end
        end
    end

    // Sum, carry-out and flags from the last level register
    always_comb begin
        fin      = lvl_q[LOG2W-1];
        carry    = '0;
        carry[0] = c_q[LOG2W-1];
        for (int i = 1; i < WIDTH; i++)
            carry[i] = fin[i-1][0];
        // Every final slot is resolved to K or G, so the high bit adds nothing
        for (int i = 0; i < WIDTH; i++)
            unused_fin_hi[i] = fin[i][1];
        sum_d  = p_q[LOG2W-1] ^ carry;
        cout_d = fin[WIDTH-1][0];
        ovf_d  = (am_q[LOG2W-1] == bm_q[LOG2W-1]) &&
                 (sum_d[WIDTH-1] != am_q[LOG2W-1]);
        zero_d = ~|sum_d;
    end

    // Data registers: advance together, no reset (only valid-qualified data matters)
    always_ff @(posedge clk) begin
        if (adv) begin
            in_a   <= bus.a;
            in_bp  <= bus.sub ? ~bus.b : bus.b;
            in_cin <= bus.sub | bus.cin;
            lvl_q  <= lvl_nxt;
            p_q[0]  <= in_a ^ in_bp;
            am_q[0] <= in_a[WIDTH-1];
            bm_q[0] <= in_bp[WIDTH-1];
            c_q[0]  <= in_cin;
            for (int l = 1; l < LOG2W; l++) begin
                p_q[l]  <= p_q[l-1];
                am_q[l] <= am_q[l-1];
                bm_q[l] <= bm_q[l-1];
                c_q[l]  <= c_q[l-1];
            end
        end
    end

    // Valid shift register and result outputs; reset flushes every beat in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
            bus.zero <= 1'b0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:0], bus.in_valid};
            bus.sum  <= sum_d;
            bus.cout <= cout_d;
            bus.ovf  <= ovf_d;
            bus.zero <= zero_d;
        end
    end
endmodule
